// File: rtl/idu_pkg.sv
// Shared control-bundle layout and RV32/RV64 encoding constants for the decode stage.
package idu_pkg;

  localparam int CTRL_W = 23;

  typedef struct packed {
    logic       illegal;
    logic       word;
    logic [2:0] ext_op;
    logic       reg_wr;
    logic [2:0] branch;
    logic       mem_to_reg;
    logic       mem_wr;
    logic [2:0] mem_op;
    logic       alu_asrc;
    logic [1:0] alu_bsrc;
    logic [4:0] alu_ctr;
  } ctrl_t;

  // The named fields occupy 22 bits; the bundle port is CTRL_W wide with a zero MSB.
  localparam int CTRL_PAD = CTRL_W - $bits(ctrl_t);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b01000;
  localparam logic [4:0] ALU_SLL   = 5'b00001;
  localparam logic [4:0] ALU_SLT   = 5'b00010;
  localparam logic [4:0] ALU_SLTU  = 5'b01010;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SRL   = 5'b00101;
  localparam logic [4:0] ALU_SRA   = 5'b01101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_AND   = 5'b00111;
  localparam logic [4:0] ALU_COPYB = 5'b00011;

  localparam logic [1:0] BSRC_RS2 = 2'b00;
  localparam logic [1:0] BSRC_IMM = 2'b01;
  localparam logic [1:0] BSRC_4   = 2'b10;
  localparam logic       ASRC_RS1 = 1'b0;
  localparam logic       ASRC_PC  = 1'b1;

  // alt selects sub/sra for the funct3 values that have an alternate form.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV64I(+M) decode: instruction word to ctrl_t, no state.
// Unrecognised or parameter-disabled encodings yield a bundle with only illegal set.
module idu_decode
  import idu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit EN_M = (HAS_M != 0);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       sh_ok;
  logic       legal;
  ctrl_t      c;
  logic       unused_bits;

  assign opc         = inst_i[6:0];
  assign f3          = inst_i[14:12];
  assign f7          = inst_i[31:25];
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

  // Shift-immediate upper bits: inst[25] is shamt[5] on RV64 and must be 0 on RV32.
  assign sh_ok = !inst_i[31] && (inst_i[29:26] == 4'b0000) && (RV64 || !inst_i[25]);

  always_comb begin
    c     = '0;
    legal = 1'b0;
    case (opc)
      OPC_LUI: begin
        legal      = 1'b1;
        c.ext_op   = EXT_U;
        c.reg_wr   = 1'b1;
        c.alu_bsrc = BSRC_IMM;
        c.alu_ctr  = ALU_COPYB;
      end
      OPC_AUIPC: begin
        legal      = 1'b1;
        c.ext_op   = EXT_U;
        c.reg_wr   = 1'b1;
        c.alu_asrc = ASRC_PC;
        c.alu_bsrc = BSRC_IMM;
        c.alu_ctr  = ALU_ADD;
      end
      OPC_JAL: begin
        legal      = 1'b1;
        c.ext_op   = EXT_J;
        c.reg_wr   = 1'b1;
        c.branch   = BR_JAL;
        c.alu_asrc = ASRC_PC;
        c.alu_bsrc = BSRC_4;
        c.alu_ctr  = ALU_ADD;
      end
      OPC_JALR: begin
        legal      = (f3 == 3'b000);
        c.ext_op   = EXT_I;
        c.reg_wr   = 1'b1;
        c.branch   = BR_JALR;
        c.alu_asrc = ASRC_PC;
        c.alu_bsrc = BSRC_4;
        c.alu_ctr  = ALU_ADD;
      end
      OPC_BRANCH: begin
        legal      = !(f3 inside {3'b010, 3'b011});
        c.ext_op   = EXT_B;
        c.branch   = {1'b1, f3[2], f3[0]};
        c.alu_bsrc = BSRC_RS2;
        c.alu_ctr  = f3[1] ? ALU_SLTU : ALU_SLT;
      end
      OPC_LOAD: begin
        legal        = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                       (RV64 && (f3 inside {3'b011, 3'b110}));
        c.ext_op     = EXT_I;
        c.reg_wr     = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_op     = f3;
        c.alu_bsrc   = BSRC_IMM;
        c.alu_ctr    = ALU_ADD;
      end
      OPC_STORE: begin
        legal      = (f3 inside {3'b000, 3'b001, 3'b010}) || (RV64 && (f3 == 3'b011));
        c.ext_op   = EXT_S;
        c.mem_wr   = 1'b1;
        c.mem_op   = f3;
        c.alu_bsrc = BSRC_IMM;
        c.alu_ctr  = ALU_ADD;
      end
      OPC_OPIMM: begin
        case (f3)
          3'b001:  legal = sh_ok && !inst_i[30];
          3'b101:  legal = sh_ok;
          default: legal = 1'b1;
        endcase
        c.ext_op   = EXT_I;
        c.reg_wr   = 1'b1;
        c.alu_bsrc = BSRC_IMM;
        c.alu_ctr  = alu_from_f3(f3, (f3 == 3'b101) && inst_i[30]);
      end
      OPC_OP: begin
        c.reg_wr   = 1'b1;
        c.alu_bsrc = BSRC_RS2;
        if (f7 == F7_BASE) begin
          legal     = 1'b1;
          c.alu_ctr = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT) begin
          legal     = (f3 inside {3'b000, 3'b101});
          c.alu_ctr = alu_from_f3(f3, 1'b1);
        end else if (EN_M && (f7 == F7_MULDIV)) begin
          legal     = 1'b1;
          c.alu_ctr = {2'b10, f3};
        end
      end
      OPC_OPIMM32: begin
        case (f3)
          3'b000:  legal = RV64;
          3'b001:  legal = RV64 && (f7 == F7_BASE);
          3'b101:  legal = RV64 && ((f7 == F7_BASE) || (f7 == F7_ALT));
          default: legal = 1'b0;
        endcase
        c.word     = 1'b1;
        c.ext_op   = EXT_I;
        c.reg_wr   = 1'b1;
        c.alu_bsrc = BSRC_IMM;
        c.alu_ctr  = alu_from_f3(f3, (f3 == 3'b101) && inst_i[30]);
      end
      OPC_OP32: begin
        c.word     = 1'b1;
        c.reg_wr   = 1'b1;
        c.alu_bsrc = BSRC_RS2;
        if (f7 == F7_BASE) begin
          legal     = RV64 && (f3 inside {3'b000, 3'b001, 3'b101});
          c.alu_ctr = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT) begin
          legal     = RV64 && (f3 inside {3'b000, 3'b101});
          c.alu_ctr = alu_from_f3(f3, 1'b1);
        end else if (f7 == F7_MULDIV) begin
          legal     = RV64 && EN_M && (f3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111});
          c.alu_ctr = {2'b10, f3};
        end
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      ctrl_o = c;
    end else begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: 1-cycle latency, full throughput; a skid entry absorbs one
// acceptance under back-pressure so in_ready can come straight from a flop.
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst
);

  ctrl_t dec_ctrl;

  idu_decode #(
    .XLEN  (XLEN),
    .HAS_M (HAS_M)
  ) u_decode (
    .inst_i (in_inst),
    .ctrl_o (dec_ctrl)
  );

  logic            in_ready_q,   in_ready_d;
  logic            out_valid_q,  out_valid_d;
  ctrl_t           out_ctrl_q,   out_ctrl_d;
  logic [XLEN-1:0] out_pc_q,     out_pc_d;
  logic [31:0]     out_inst_q,   out_inst_d;
  logic            skid_valid_q, skid_valid_d;
  ctrl_t           skid_ctrl_q,  skid_ctrl_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic [31:0]     skid_inst_q,  skid_inst_d;

  logic accept;
  logic out_free;

  assign accept   = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready is low while skid is full, so skid and a new acceptance never coincide.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_pc_d     = skid_pc_q;
        out_inst_d   = skid_inst_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = dec_ctrl;
        out_pc_d    = in_pc;
        out_inst_d  = in_inst;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = dec_ctrl;
      skid_pc_d    = in_pc;
      skid_inst_d  = in_inst;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= '0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_ctrl_q   <= out_ctrl_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = {{CTRL_PAD{1'b0}}, out_ctrl_q};
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench: an RV32 no-M stage and an RV64 with-M stage share stimulus and are both checked.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc32;
  logic [63:0] in_pc64;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [22:0] a_out_ctrl;
  logic [31:0] a_out_pc, a_out_inst;
  logic        b_in_ready, b_out_valid;
  logic [22:0] b_out_ctrl;
  logic [63:0] b_out_pc;
  logic [31:0] b_out_inst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .HAS_M(0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc32), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_pc(a_out_pc), .out_inst(a_out_inst)
  );

  idu_stage #(.XLEN(64), .HAS_M(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc64), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_pc(b_out_pc), .out_inst(b_out_inst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Fields in bundle order, MSB first, under a zero pad bit.
  function automatic logic [22:0] mk(input logic ill, input logic word, input logic [2:0] ext,
                                     input logic regwr, input logic [2:0] br, input logic m2r,
                                     input logic mwr, input logic [2:0] mop, input logic asrc,
                                     input logic [1:0] bsrc, input logic [4:0] alu);
    return {1'b0, ill, word, ext, regwr, br, m2r, mwr, mop, asrc, bsrc, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc32  = pc;
    in_pc64  = {32'hA5A5_0000, pc};
  endtask

  task automatic dec_case(input string tag, input logic [31:0] inst,
                          input logic [22:0] exp_a, input logic [22:0] exp_b);
    drive(1'b1, inst, 32'h0000_2000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk({tag, "_vld"}, 64'(a_out_valid & b_out_valid), 64'd1);
    chk({tag, "_rv32"}, 64'(a_out_ctrl), 64'(exp_a));
    chk({tag, "_rv64"}, 64'(b_out_ctrl), 64'(exp_b));
  endtask

  localparam logic [31:0] I_ADDI5 = 32'h0050_0093;
  localparam logic [31:0] I_ADDI6 = 32'h0060_0113;
  localparam logic [31:0] I_ADDI7 = 32'h0070_0193;

  logic [22:0] ill, c_addi;

  initial begin
    ill    = mk(1, 0, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 2'b00, 5'b00000);
    c_addi = mk(0, 0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b01, 5'b00000);
    rst_n = 1'b1;
    out_ready = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("rst_ctrl", 64'(a_out_ctrl | b_out_ctrl), 64'd0);
    chk("rst_pc_inst", {a_out_pc, a_out_inst}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single decode with full pass-through of pc/inst.
    out_ready = 1'b1;
    drive(1'b1, I_ADDI5, 32'h0000_1000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_vld", 64'(a_out_valid), 64'd1);
    chk("addi_ctrl", 64'(a_out_ctrl), 64'(c_addi));
    chk("addi_inst", 64'(a_out_inst), 64'(I_ADDI5));
    chk("addi_pc32", 64'(a_out_pc), 64'h1000);
    chk("addi_pc64", b_out_pc, 64'hA5A5_0000_0000_1000);
    tick();
    chk("idle_vld", 64'(a_out_valid | b_out_valid), 64'd0);

    dec_case("mul", 32'h0220_8033, ill, mk(0, 0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b00, 5'b10000));
    dec_case("addw", 32'h0020_803B, ill, mk(0, 1, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b00, 5'b00000));
    dec_case("bltu", 32'h0020_E063, mk(0, 0, 3'b011, 0, 3'b110, 0, 0, 3'b000, 0, 2'b00, 5'b01010),
             mk(0, 0, 3'b011, 0, 3'b110, 0, 0, 3'b000, 0, 2'b00, 5'b01010));
    dec_case("lwu", 32'h0000_E083, ill, mk(0, 0, 3'b000, 1, 3'b000, 1, 0, 3'b110, 0, 2'b01, 5'b00000));
    dec_case("sd", 32'h0020_B023, ill, mk(0, 0, 3'b010, 0, 3'b000, 0, 1, 3'b011, 0, 2'b01, 5'b00000));
    dec_case("sub", 32'h4020_8033, mk(0, 0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b00, 5'b01000),
             mk(0, 0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b00, 5'b01000));
    dec_case("xor_alt", 32'h4020_C033, ill, ill);
    dec_case("slli32", 32'h0200_9093, ill, mk(0, 0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 2'b01, 5'b00001));
    dec_case("jal", 32'h0000_00EF, mk(0, 0, 3'b100, 1, 3'b001, 0, 0, 3'b000, 1, 2'b10, 5'b00000),
             mk(0, 0, 3'b100, 1, 3'b001, 0, 0, 3'b000, 1, 2'b10, 5'b00000));
    dec_case("low_bits", 32'h0000_0010, ill, ill);
    tick();

    // Back-pressure: A held, B in skid, C refused until space frees up.
    out_ready = 1'b0;
    drive(1'b1, I_ADDI5, 32'h100);
    tick();
    chk("bp_a_vld", 64'(a_out_valid), 64'd1);
    chk("bp_rdy1", 64'(a_in_ready), 64'd1);
    drive(1'b1, I_ADDI6, 32'h104);
    tick();
    chk("bp_rdy2", 64'(a_in_ready | b_in_ready), 64'd0);
    chk("bp_hold_a", 64'(a_out_inst), 64'(I_ADDI5));
    drive(1'b1, I_ADDI7, 32'h108);
    tick();
    chk("bp_rdy3", 64'(a_in_ready), 64'd0);
    chk("bp_stable", {a_out_pc, a_out_inst}, {32'h100, I_ADDI5});
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", {a_out_pc, a_out_inst}, {32'h104, I_ADDI6});
    chk("bp_rdy4", 64'(a_in_ready), 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_out_c", {a_out_pc, a_out_inst}, {32'h108, I_ADDI7});
    chk("bp_out_c64", b_out_pc, 64'hA5A5_0000_0000_0108);
    chk("bp_c_vld", 64'(a_out_valid), 64'd1);
    tick();
    chk("bp_nodup", 64'(a_out_valid | b_out_valid), 64'd0);

    // Flush with output and skid both occupied.
    out_ready = 1'b0;
    drive(1'b1, I_ADDI5, 32'h200);
    tick();
    drive(1'b1, I_ADDI6, 32'h204);
    tick();
    chk("fl_full", 64'(a_in_ready), 64'd0);
    drive(1'b1, I_ADDI7, 32'h208);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_vld", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("fl_rdy", 64'(a_in_ready & b_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_gone", 64'(a_out_valid | b_out_valid), 64'd0);

    // Flush dropping a same-cycle acceptance while skid is empty.
    out_ready = 1'b0;
    drive(1'b1, I_ADDI5, 32'h300);
    tick();
    drive(1'b1, I_ADDI6, 32'h304);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl2_vld", 64'(a_out_valid), 64'd0);
    chk("fl2_rdy", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl2_drop", 64'(a_out_valid | b_out_valid), 64'd0);

    // Asynchronous reset between edges while holding a valid instruction.
    out_ready = 1'b0;
    drive(1'b1, I_ADDI7, 32'h400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_pre_vld", 64'(a_out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("ar_ctrl", 64'(a_out_ctrl | b_out_ctrl), 64'd0);
    chk("ar_pc_inst", {a_out_pc, a_out_inst}, 64'd0);
    chk("ar_pc64", b_out_pc, 64'd0);
    chk("ar_rdy", 64'(a_in_ready & b_in_ready), 64'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_after", 64'(a_out_valid | b_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
# idu_stage

Registered, parametrised instruction-decode stage for the NPC core, replacing the single-cycle combinational control decode when the core moves to a pipelined IFU→IDU→EXU organisation. It takes fetched instructions over a valid/ready handshake, decodes RV32I/RV64I plus optional M, and presents a registered control bundle with an illegal-instruction flag. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; 64 enables the W-ops, `ld`/`lwu`/`sd` and 6-bit shamt.
- `HAS_M`, 0: 1 decodes the M extension (OP/OP-32 with funct7=0000001).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: the IFU is offering an instruction.
- `in_ready` out 1: the stage can accept; driven directly from a flop.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: PC of `in_inst`.
- `flush` in 1: discard all held and accepted-this-cycle instructions.
- `out_valid` out 1: `out_ctrl`/`out_pc`/`out_inst` are valid.
- `out_ready` in 1: the EXU accepts.
- `out_ctrl` out `CTRL_W`: decoded control bundle (see Structure).
- `out_pc` out XLEN; `out_inst` out 32: passed through with the bundle.

## Operation
- Decode is combinational on `in_inst` and is captured into the output register on acceptance (`in_valid && in_ready`).
- Decoded classes:
  - LUI, AUIPC, JAL, JALR (funct3=000 only).
  - Branches with funct3 in {000,001,100,101,110,111}.
  - Loads: lb/lh/lw/lbu/lhu, plus ld/lwu when XLEN=64.
  - Stores: sb/sh/sw, plus sd when XLEN=64.
  - OP-IMM and OP; OP-IMM-32 and OP-32 when XLEN=64.
  - M ops when HAS_M=1.
- Legality checks:
  - The shift-immediate upper bits must be 0000000 or 0100000 (inst[31:26] when XLEN=64).
  - OP funct7 must be 0000000, 0100000 (only for add→sub and srl→sra), or 0000001 with HAS_M.
- Any other encoding, or inst[1:0]≠11, is illegal. The bundle then has illegal=1, RegWr=0, MemWr=0, Branch=000, and the other fields 0.
- Word flag: set for OP-IMM-32/OP-32 (the EXU sign-extends the 32-bit result).
- M ops: ALUctr = {1, 1'b0, funct3}; all other ALUctr values have bit4=0.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`. Throughput: 1 instruction per cycle while `out_ready`=1.
- Output register and skid register:
  - The skid register fills only when the output register holds valid data, `out_ready`=0, and an acceptance occurs.
  - `in_ready` = !skid_valid, registered.
  - When the output register drains, the skid entry moves into it on the same edge.
- Holding: `out_*` stay stable while `out_valid && !out_ready`. The EXU may sample at any cycle.
- Flush: on the next edge, out_valid=0 and skid_valid=0, and any same-cycle acceptance is dropped. `in_ready`=1 the cycle after. Flush has priority over every other event.
- Simultaneous drain and accept with skid empty: the new instruction goes to the output register and skid stays empty.
- Reset (any time, including mid-transfer):
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_ctrl, out_pc and out_inst are all 0.
  - No instruction survives reset.

## Structure
- Package `idu_pkg` holds the field widths, the `ctrl_t` packed struct and the encoding constants below. `CTRL_W` = 23.
- `ctrl_t` fields, MSB→LSB: illegal[1], word[1], ExtOP[3], RegWr[1], Branch[3], MemToReg[1], MemWr[1], MemOP[3], ALUAsrc[1], ALUBsrc[2], ALUctr[5].
- ExtOP: I=000, U=001, S=010, B=011, J=100.
- Branch: none=000, jal=001, jalr=010, eq=100, ne=101, lt=110, ge=111.
- MemOP:
  - b=000, h=001, w=010, d=011.
  - bu=100, hu=101, wu=110.
- ALUctr:
  - add=00000, sub=01000, sll=00001, slt=00010, sltu=01010.
  - xor=00100, srl=00101, sra=01101, or=00110, and=00111, copyB=00011.
  - Unsigned branches use sltu; signed branches use slt.
- ALUBsrc: rs2=00, imm=01, 4=10. ALUAsrc: rs1=0, pc=1.
- Sub-module `idu_decode`: purely combinational, inst → `ctrl_t`, parametrised by XLEN and HAS_M. It is instantiated once. The top holds the handshake and skid logic.

## Test plan
- **Single decode.** Reset, then `addi x1,x0,5` (0x00500093) with `out_ready`=1 → the next cycle out_valid=1 and out_ctrl = illegal 0, word 0, ExtOP 000, RegWr 1, ALUBsrc 01, ALUctr 00000.
- **Back-pressure.** Stream 3 instructions with `out_ready`=0 → the first is held, the second goes to skid, and `in_ready` drops after the second. Raising `out_ready` → all 3 are delivered in order over 3 cycles with no duplicates.
- **Illegal and parameter-gated encodings.** `mul` (0x02208033) with HAS_M=0 → illegal=1, RegWr=0. With HAS_M=1 → ALUctr=10000. `addw` (0x0020803B) with XLEN=32 → illegal=1. With XLEN=64 → word=1, ALUctr=00000.
- **Flush with both entries full.** Fill output and skid, then assert `flush` together with `in_valid` → the next cycle out_valid=0 and in_ready=1, and no flushed instruction ever appears.
- **Branch and load encodings.** `bltu` (0x0020E063) → ExtOP 011, Branch 110, ALUctr 01010, RegWr 0. `lwu` (0x0000E083) with XLEN=64 → MemToReg 1, MemOP 110.
- **Asynchronous reset mid-stream.** Assert `rst_n`=0 between clock edges while out_valid=1 → all outputs are 0 immediately and in_ready=1.
